// File: rtl/uart_tx_byte_if.sv
// Byte-in / serial-out handshake bundle for uart_tx_byte.
// The upstream sequencer uses the master modport; the transmitter uses the slave modport.
interface uart_tx_byte_if;
  logic [7:0] data_in;
  logic       SEND;
  logic       BUSY;
  logic       TX;
  logic       DONE;

  modport master (
    output data_in,
    output SEND,
    input  BUSY,
    input  TX,
    input  DONE
  );

  modport slave (
    input  data_in,
    input  SEND,
    output BUSY,
    output TX,
    output DONE
  );
endinterface

// File: rtl/uart_tx_byte.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to compile in the PARITY state.
module uart_tx_byte #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned STOP_BITS = 1
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_byte_if.slave bus
);

  localparam logic [15:0] BaudReload = 16'(CLK_DIV - 1);
  localparam logic [2:0]  StopLast   = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        baud_last;

`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign baud_last = (baud_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_last ? BaudReload : baud_q - 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        baud_d = 16'd0;
        if (bus.SEND) begin
          state_d  = StStart;
          baud_d   = BaudReload;
          bit_d    = 3'd0;
          shift_d  = bus.data_in;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^bus.data_in;
`endif
        end
      end
      StStart: begin
        if (baud_last) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        // Registered DONE: set one clock early so it is high in the last stop clock.
        done_d = (baud_q == 16'd1) && (bit_q == StopLast);
        if (baud_last) begin
          if (bit_q == StopLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            baud_d  = 16'd0;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        baud_d  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.TX   = tx_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Directed bench for uart_tx_byte with CLK_DIV=4: one instance with one stop bit, one with two.
// Frames are captured cycle by cycle at the falling edge and compared with hand-derived waves.
module tb_uart_tx_byte;

  localparam int ClkDiv = 4;
`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_tx_byte_if bus_a ();
  uart_tx_byte_if bus_b ();

  uart_tx_byte #(.CLK_DIV(ClkDiv), .STOP_BITS(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  uart_tx_byte #(.CLK_DIV(ClkDiv), .STOP_BITS(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int flen(input int stops);
    return (9 + Par + stops) * ClkDiv;
  endfunction

  // Per-cycle TX wave: frame bits for flen cycles, then idle-high up to total samples.
  function automatic logic [63:0] exp_tx(input logic [7:0] d, input int stops, input int total);
    logic [11:0] bits;
    logic [63:0] r;
    int          len;
    len       = flen(stops);
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (Par == 1) bits[9] = ^d;
    r = '0;
    for (int k = 0; k < total; k++) r[k] = (k < len) ? bits[k / ClkDiv] : 1'b1;
    return r;
  endfunction

  task automatic drive(input bit sel, input logic send, input logic [7:0] d);
    if (sel) begin
      bus_b.SEND    = send;
      bus_b.data_in = d;
    end else begin
      bus_a.SEND    = send;
      bus_a.data_in = d;
    end
  endtask

  task automatic sample(input bit sel, output logic tx, output logic busy, output logic done);
    tx   = sel ? bus_b.TX   : bus_a.TX;
    busy = sel ? bus_b.BUSY : bus_a.BUSY;
    done = sel ? bus_b.DONE : bus_a.DONE;
  endtask

  // mode 1 toggles data_in and pulses SEND while the data bits are on the line.
  task automatic frame_test(input bit sel, input bit pre, input int mode, input logic [7:0] d,
                            input string tag, input logic [63:0] mid_exp);
    int          stops, len, total;
    logic [63:0] tx_v, busy_v, done_v, busy_e, done_e, mid;
    logic        t, b, dn;
    stops = sel ? 2 : 1;
    len   = flen(stops);
    total = len + 9;
    if (!pre) begin
      @(negedge clk);
      drive(sel, 1'b1, d);
    end
    tx_v = '0; busy_v = '0; done_v = '0; busy_e = '0; done_e = '0; mid = '0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      sample(sel, t, b, dn);
      tx_v[k]   = t;
      busy_v[k] = b;
      done_v[k] = dn;
      busy_e[k] = (k < len);
      done_e[k] = (k == len - 1);
      if (mode == 1 && k >= 6 && k < 34) drive(sel, (k == 10 || k == 11 || k == 20), 8'($urandom));
      else if (k == 0) drive(sel, 1'b0, ~d);
    end
    for (int j = 0; j < 9 + Par + stops; j++) mid[j] = tx_v[j * ClkDiv + 2];
    check({tag, "_tx"},   tx_v,   exp_tx(d, stops, total));
    check({tag, "_busy"}, busy_v, busy_e);
    check({tag, "_done"}, done_v, done_e);
    check({tag, "_bits"}, mid,    mid_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tx_v, busy_v, busy_e;
    logic [7:0]  dec;
    logic        t, b, dn, done_seen, busy_seen;
    int          len;

    // SEND held high through reset must not be accepted before rst_n rises.
`ifdef UART_TX_PARITY_EN
    drive(1'b0, 1'b1, 8'hA5);
`else
    drive(1'b0, 1'b1, 8'h55);
`endif
    drive(1'b1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_a", 64'({bus_a.TX, bus_a.BUSY, bus_a.DONE}), 64'(3'b100));
    check("reset_b", 64'({bus_b.TX, bus_b.BUSY, bus_b.DONE}), 64'(3'b100));
    rst_n = 1'b1;

`ifdef UART_TX_PARITY_EN
    frame_test(1'b0, 1'b1, 0, 8'hA5, "byte_a5", 64'h54A);
    frame_test(1'b0, 1'b0, 0, 8'h01, "byte_01", 64'h602);
    frame_test(1'b1, 1'b0, 0, 8'h80, "stop2_80", 64'hF00);
    frame_test(1'b0, 1'b0, 1, 8'h3C, "ignore_3c", 64'h478);
`else
    frame_test(1'b0, 1'b1, 0, 8'h55, "byte_55", 64'h2AA);
    frame_test(1'b0, 1'b0, 0, 8'h01, "byte_01", 64'h202);
    frame_test(1'b1, 1'b0, 0, 8'h80, "stop2_80", 64'h700);
    frame_test(1'b0, 1'b0, 1, 8'h3C, "ignore_3c", 64'h278);
`endif

    // Reset pulse in the middle of data bit 3.
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00);
    done_seen = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      sample(1'b0, t, b, dn);
      done_seen |= dn;
      if (k == 0) drive(1'b0, 1'b0, 8'h00);
    end
    check("abort_pre_busy", 64'(b), 64'(1));
    #1 rst_n = 1'b0;
    #1 sample(1'b0, t, b, dn);
    check("abort_in_reset", 64'({t, b, dn}), 64'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      sample(1'b0, t, b, dn);
      done_seen |= dn;
      busy_seen |= b;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));
    check("abort_idle", 64'(busy_seen), 64'(0));
`ifdef UART_TX_PARITY_EN
    frame_test(1'b0, 1'b0, 0, 8'hFF, "after_rst_ff", 64'h5FE);
`else
    frame_test(1'b0, 1'b0, 0, 8'hFF, "after_rst_ff", 64'h3FE);
`endif

    // Back-to-back stream: SEND stays high, next byte presented right after each acceptance.
    len = flen(1);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 51; i++) begin
      tx_v = '0; busy_v = '0; busy_e = '0; dec = '0;
      for (int k = 0; k <= len; k++) begin
        @(negedge clk);
        sample(1'b0, t, b, dn);
        tx_v[k]   = t;
        busy_v[k] = b;
        busy_e[k] = (k < len);
        if (k == 0) drive(1'b0, (i < 50), 8'(i + 1));
      end
      for (int j = 0; j < 8; j++) dec[j] = tx_v[(j + 1) * ClkDiv + 2];
      check($sformatf("seq%0d_tx", i), tx_v, exp_tx(8'(i), 1, len + 1));
      check($sformatf("seq%0d_busy", i), busy_v, busy_e);
      check($sformatf("seq%0d_byte", i), 64'(dec), 64'(i));
    end
    busy_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sample(1'b0, t, b, dn);
      busy_seen |= b;
    end
    check("seq_end_idle", 64'(busy_seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
